// File: rtl/row_mem_pingpong_pkg.sv
// Shared defaults and fill-FSM encoding for the ping-pong row memory.
package row_mem_pingpong_pkg;

    localparam int DEF_INPUT_BW     = 8;
    localparam int DEF_ROW_MEM_ADDR = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FREE = 2'd1,
        ST_FILL      = 2'd2,
        ST_DONE      = 2'd3
    } fill_state_t;

endpackage

// File: rtl/row_mem_bank_ram.sv
// One row-memory bank: single write port, single registered read port.
module row_mem_bank_ram
    import row_mem_pingpong_pkg::*;
#(
    parameter int DATA_W = DEF_INPUT_BW,
    parameter int ADDR_W = DEF_ROW_MEM_ADDR
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [2**ADDR_W];

    // Storage and read register carry no reset; contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/row_mem_pingpong.sv
// Two-bank row memory: loader fills one bank over a byte stream while the PE reads the other.
module row_mem_pingpong
    import row_mem_pingpong_pkg::*;
#(
    parameter int INPUT_BW     = DEF_INPUT_BW,
    parameter int ROW_MEM_ADDR = DEF_ROW_MEM_ADDR
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       load_start,
    input  logic [ROW_MEM_ADDR-1:0]    load_len,
    input  logic signed [INPUT_BW-1:0] wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic                       load_busy,
    output logic                       load_done,
    input  logic [ROW_MEM_ADDR-1:0]    rd_addr,
    input  logic                       rd_en,
    output logic signed [INPUT_BW-1:0] rd_data,
    output logic                       rd_valid,
    output logic                       row_ready,
    input  logic                       rd_release,
    output logic                       rd_err
);

    fill_state_t                state, state_nxt;
    logic                       fill_ptr, rd_ptr;
    logic [1:0]                 bank_valid, bank_set, bank_clr;
    logic [ROW_MEM_ADDR-1:0]    len_q, wr_cnt;
    logic                       load_accept, beat, last_beat, release_ok;
    logic [1:0]                 bank_we, bank_re;
    logic signed [INPUT_BW-1:0] bank_q [2];
    logic                       rd_sel_p1, rd_zero_p1;

    assign load_accept = (state == ST_IDLE) && load_start && (load_len != '0);
    assign beat        = (state == ST_FILL) && wr_valid;
    assign last_beat   = beat && (wr_cnt == len_q - 1'b1);
    assign row_ready   = bank_valid[rd_ptr];
    assign release_ok  = rd_release && row_ready;
    assign load_busy   = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        load_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_accept) begin
                    state_nxt = bank_valid[fill_ptr] ? ST_WAIT_FREE : ST_FILL;
                end
            end
            ST_WAIT_FREE: begin
                if (!bank_valid[fill_ptr]) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A completing fill and a release always touch different banks, so set/clear compose freely.
    assign bank_set = (state == ST_DONE) ? (2'b01 << fill_ptr) : 2'b00;
    assign bank_clr = release_ok ? (2'b01 << rd_ptr) : 2'b00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            fill_ptr   <= 1'b0;
            rd_ptr     <= 1'b0;
            bank_valid <= 2'b00;
            len_q      <= '0;
            wr_cnt     <= '0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_sel_p1  <= 1'b0;
            rd_zero_p1 <= 1'b1;
        end else begin
            state      <= state_nxt;
            bank_valid <= (bank_valid & ~bank_clr) | bank_set;
            if (state == ST_DONE) begin
                fill_ptr <= ~fill_ptr;
            end
            if (release_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            if (load_accept) begin
                len_q  <= load_len;
                wr_cnt <= '0;
            end else if (beat) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            // p0 -> p1: read request registered alongside the RAM read.
            rd_valid <= rd_en;
            rd_err   <= rd_err | (rd_en & ~row_ready);
            if (rd_en) begin
                rd_sel_p1  <= rd_ptr;
                rd_zero_p1 <= ~row_ready;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = beat && (fill_ptr == 1'(b));
        assign bank_re[b] = rd_en && row_ready && (rd_ptr == 1'(b));

        row_mem_bank_ram #(
            .DATA_W(INPUT_BW),
            .ADDR_W(ROW_MEM_ADDR)
        ) u_ram (
            .clk    (clk),
            .wr_en  (bank_we[b]),
            .wr_addr(wr_cnt),
            .wr_data(wr_data),
            .rd_en  (bank_re[b]),
            .rd_addr(rd_addr),
            .rd_data(bank_q[b])
        );
    end

    assign rd_data = rd_zero_p1 ? '0 : bank_q[rd_sel_p1];

endmodule
